// File: rtl/mcu_core_param_if.sv
// Control, load-port and output-port bundle for mcu_core_param.
// master drives start and the load port; slave is the core.
interface mcu_core_param_if #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 5
);
    logic              start;
    logic              prog_we;
    logic              prog_sel;
    logic [PC_W-1:0]   prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              busy;
    logic              halted;
    logic [PC_W-1:0]   pc_out;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;

    modport master (
        output start, prog_we, prog_sel, prog_addr, prog_data,
        input  busy, halted, pc_out, out_data, out_valid
    );

    modport slave (
        input  start, prog_we, prog_sel, prog_addr, prog_data,
        output busy, halted, pc_out, out_data, out_valid
    );
endinterface

// File: rtl/mcu_core_param.sv
// Parametrised 4-register core with a FETCH/EXEC sequencer, page-relative JZ and an output port.
// Optional macro MCU_SINGLE_STEP_EN adds a step input that gates each FETCH.
//
// state | meaning
// IDLE  | after reset, load port open, waiting for start
// FETCH | latch pmem[pc] into instr (stalls without step when single-step is built in)
// EXEC  | execute instr, advance pc or halt
// HALT  | self-loop JZ reached, load port open, waiting for start
module mcu_core_param #(
    parameter int DATA_W     = 8,
    parameter int PMEM_DEPTH = 32,
    parameter int DMEM_DEPTH = 16
) (
    input logic clk,
    input logic rst_n,
`ifdef MCU_SINGLE_STEP_EN
    input logic step,
`endif
    mcu_core_param_if.slave bus
);
    localparam int PC_W = $clog2(PMEM_DEPTH);
    localparam int DA_W = $clog2(DMEM_DEPTH);
    localparam logic [DA_W-1:0] OUT_ADDR = DA_W'(DMEM_DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [7:0]        instr;
    logic [DATA_W-1:0] rf [4];
    logic [DATA_W-1:0] port_data;
    logic              port_valid;
    logic              busy;
    logic              halted;

    logic [7:0]        pmem [PMEM_DEPTH];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];

    logic [1:0]        op, ra, rb, fn;
    logic [3:0]        imm;
    logic [DA_W-1:0]   daddr;
    logic [DATA_W-1:0] alu_res;
    logic [PC_W-1:0]   jz_target;
    logic [PC_W-1:0]   pc_inc;
    logic [7:0]        pd8;
    logic              step_ok;

    assign op        = instr[7:6];
    assign ra        = instr[5:4];
    assign rb        = instr[3:2];
    assign fn        = instr[1:0];
    assign imm       = instr[3:0];
    assign daddr     = imm[DA_W-1:0];
    assign pc_inc    = pc + PC_W'(1);
    // Jump stays inside the current 16-instruction page.
    assign jz_target = (pc & ~PC_W'(15)) | PC_W'(imm);

`ifdef MCU_SINGLE_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    generate
        if (DATA_W >= 8) begin : g_pd_wide
            assign pd8 = bus.prog_data[7:0];
        end else begin : g_pd_narrow
            assign pd8 = {{(8 - DATA_W){1'b0}}, bus.prog_data};
        end
    endgenerate

    always_comb begin
        alu_res = '0;
        case (fn)
            2'b00: alu_res = rf[ra] + rf[rb];
            2'b01: alu_res = rf[ra] - rf[rb];
            2'b10: alu_res = rf[ra] & rf[rb];
            2'b11: alu_res = rf[ra] ^ rf[rb];
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state      <= S_IDLE;
            pc         <= '0;
            instr      <= '0;
            port_data  <= '0;
            port_valid <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else begin
            port_valid <= 1'b0;
            case (state)
                S_IDLE, S_HALT: begin
                    if (bus.start) begin
                        state  <= S_FETCH;
                        pc     <= '0;
                        busy   <= 1'b1;
                        halted <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (step_ok) begin
                        instr <= pmem[pc];
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    pc    <= pc_inc;
                    case (op)
                        2'b00: rf[ra] <= dmem[daddr];
                        2'b01: begin
                            if (daddr == OUT_ADDR) begin
                                port_data  <= rf[ra];
                                port_valid <= 1'b1;
                            end
                        end
                        2'b10: rf[ra] <= alu_res;
                        2'b11: begin
                            if (rf[ra] == '0) begin
                                if (jz_target == pc) begin
                                    state  <= S_HALT;
                                    pc     <= pc;
                                    busy   <= 1'b0;
                                    halted <= 1'b1;
                                end else begin
                                    pc <= jz_target;
                                end
                            end
                        end
                    endcase
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Memories are deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (bus.prog_we && !busy) begin
            if (bus.prog_sel) dmem[bus.prog_addr[DA_W-1:0]] <= bus.prog_data;
            else              pmem[bus.prog_addr]           <= pd8;
        end
        if (state == S_EXEC && op == 2'b01) dmem[daddr] <= rf[ra];
    end

    assign bus.busy      = busy;
    assign bus.halted    = halted;
    assign bus.pc_out    = pc;
    assign bus.out_data  = port_data;
    assign bus.out_valid = port_valid;
endmodule

// File: doc/mcu_core_param.md
Name: mcu_core_param

Overview:
- Parametrised successor to the team's 4-register 8-bit teaching CPU.
- Adds configurable data width and memory depths, a load port for program and data memory, a start/halt handshake, a two-phase FETCH/EXEC sequencer, page-relative jumps, and a memory-mapped output port.
- Sits behind the tile top level.
- Program and data are loaded while the core is idle; results are read from the output port.

Parameters:
- DATA_W, 8, register, ALU and data-memory word width (≥4).
- PMEM_DEPTH, 32, program memory depth in 8-bit instructions; power of 2, 16..256; PC_W = clog2(PMEM_DEPTH).
- DMEM_DEPTH, 16, data memory depth in DATA_W words; power of 2, ≤16.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high.
- start  in  1  begin execution at PC=0; honoured only in IDLE or HALT.
- prog_we  in  1  load-port write strobe; honoured only when busy=0.
- prog_sel  in  1  load target: 0 = program memory, 1 = data memory.
- prog_addr  in  PC_W  load address; data memory uses the low clog2(DMEM_DEPTH) bits.
- prog_data  in  DATA_W  load data; program memory takes bits [7:0].
- busy  out  1  high in FETCH/EXEC.
- halted  out  1  high in HALT.
- pc_out  out  PC_W  current PC.
- out_data  out  DATA_W  last value stored to address DMEM_DEPTH-1.
- out_valid  out  1  one-cycle pulse when out_data updates.

Behaviour:
- Reset (rst_n=1, async):
  - state=IDLE, PC=0, all 4 registers=0, instr latch=0, out_data=0, out_valid=0, busy=0, halted=0.
  - Program and data memories are NOT reset; contents survive reset.
- States:
  - IDLE: start → FETCH with PC=0.
  - FETCH: instr <= pmem[PC] → EXEC.
  - EXEC: execute instr, update PC → FETCH, or → HALT.
  - HALT: start → FETCH with PC=0.
- Timing: exactly 2 cycles per instruction. First FETCH is the cycle after start is sampled.
- Instruction fields: op=[7:6], rA=[5:4], rB=[3:2], fn=[1:0], imm=[3:0]. Data address = imm mod DMEM_DEPTH.
- op 00 LD: rA <= dmem[addr].
- op 01 ST: dmem[addr] <= rA. If addr==DMEM_DEPTH-1, also out_data <= rA and out_valid=1 for the next cycle only.
- op 10 ALU: rA <= rA op rB, where fn 00 ADD, 01 SUB, 10 AND, 11 XOR. Results wrap modulo 2^DATA_W; no carry is kept. rA==rB is legal and uses the old value.
- op 11 JZ:
  - Target = {PC[PC_W-1:4], imm} (same 16-instruction page).
  - If rA==0 and target==PC: HALT (self-loop halt).
  - Else if rA==0: PC <= target.
  - Else: PC <= PC+1.
- PC+1 wraps modulo PMEM_DEPTH.
- Load port:
  - Writes occur on the clock edge when prog_we=1 and busy=0.
  - While busy=1, writes are dropped silently.
  - prog_we and start in the same IDLE/HALT cycle: the write lands, and the following FETCH sees the new data.
- start while busy is ignored.
- Reset mid-run aborts immediately. No partial register write occurs after rst_n asserts.
- out_valid never asserts outside EXEC+1.

Optional Feature:
- Macro: MCU_SINGLE_STEP_EN.
- When defined:
  - Adds input port step (1 bit).
  - In FETCH, the core stalls (PC and state hold, busy=1) until step=1 is sampled.
  - One instruction executes per step pulse; a held step runs continuously.
  - start still launches from IDLE/HALT without needing step.
- When undefined: no step port; FETCH never stalls.

Test Plan (DATA_W=8, PMEM_DEPTH=32, DMEM_DEPTH=16):
1. Reset behaviour:
   - Stimulus: assert rst_n=1 mid-clock.
   - Required response: busy=0, halted=0, pc_out=0, out_valid=0, out_data=0 immediately, without waiting for a clock edge.
2. ADD to output port:
   - Stimulus: load dmem[2]=5, dmem[3]=7 and pmem[0..4]=02,13,84,4F,E4; pulse start.
   - Required response: out_data=0x0C with a single out_valid pulse; halted=1 and pc_out=4 exactly 10 cycles after start was sampled.
3. SUB wrap:
   - Stimulus: dmem[2]=3, dmem[3]=7, same program with pmem[2]=85.
   - Required response: out_data=0xFC.
4. JZ not-taken and taken:
   - Stimulus: r0=1 with JZ r0 to 6 → falls through to PC+1. r2=0 with JZ r2 to 6 (pmem=E6) at PC 1 → PC=6.
   - Additional: PC at 31 with a non-jump instruction wraps to PC=0.
5. Busy-time load and start ignored:
   - Stimulus: prog_we to pmem[4] and a start pulse while busy.
   - Required response: the original program runs to HALT unchanged; pmem[4] is still E4.
6. Reset mid-run:
   - Stimulus: assert rst_n during EXEC of instruction 2, release it, pulse start.
   - Required response: identical result (out_data=0x0C), proving memories are retained and registers cleared.
   - With MCU_SINGLE_STEP_EN: step held at 0 keeps pc_out=0 and busy=1 indefinitely.
